// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] INST_NOP           = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_ADDR_DEFAULT = 32'h0000_0000;

    // One buffered fetch: instruction word plus the byte address it came from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {inst, addr} pairs; head is always in mem0.
module fetch_buffer
    import instruction_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem0, mem1;
    logic [ENTRY_W-1:0] mem0_n, mem1_n;
    logic [1:0]         count_n;

    // Pop shifts mem1 into the head first, so a same-cycle push lands behind it.
    always_comb begin
        mem0_n  = mem0;
        mem1_n  = mem1;
        count_n = count;
        if (flush) begin
            count_n = 2'd0;
        end else begin
            if (pop && (count != 2'd0)) begin
                mem0_n  = mem1;
                count_n = count - 2'd1;
            end
            if (push && (count_n != 2'd2)) begin
                if (count_n == 2'd0) begin
                    mem0_n = din;
                end else begin
                    mem1_n = din;
                end
                count_n = count_n + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            mem0  <= mem0_n;
            mem1  <= mem1_n;
            count <= count_n;
        end
    end

    assign dout = mem0;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ROM request issue, redirect handling and a 2-deep instruction queue.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            hold,
    output logic            rom_req,
    output logic [XLEN-1:0] rom_addr,
    input  logic [XLEN-1:0] rom_data,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_addr,
    output logic            inst_valid
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] jump_target;
    logic            inflight;
    logic            drop;
    logic            pop;
    logic            push;
    logic            issue;
    logic [1:0]      count;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    fetch_buffer u_fetch_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (jump_en),
        .din   (wr_entry),
        .dout  (head),
        .count (count)
    );

    assign jump_target = jump_addr & ~XLEN'(3);

    // Issue only while buffered plus outstanding words still fit after this cycle's pop.
    always_comb begin
        pop   = inst_valid & ~hold & ~jump_en;
        issue = rst_n & ~jump_en
              & ((3'(count) + 3'(inflight)) < (3'd2 + 3'(pop)));
        push  = inflight & ~drop & ~jump_en;
        wr_entry.inst = rom_data;
        wr_entry.addr = req_addr;
    end

    assign rom_req  = issue;
    assign rom_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_ADDR;
            req_addr <= '0;
            inflight <= 1'b0;
            drop     <= 1'b0;
        end else begin
            inflight <= issue;
            drop     <= jump_en & inflight;
            if (jump_en) begin
                pc <= jump_target;
            end else if (issue) begin
                pc       <= pc + XLEN'(4);
                req_addr <= pc;
            end
        end
    end

    assign inst_valid = (count != 2'd0);
    assign inst       = inst_valid ? head.inst : INST_NOP;
    assign inst_addr  = inst_valid ? head.addr : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 1-cycle-latency ROM model.
`timescale 1ns/1ps
module tb_instruction_fetch;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] ROM_KEY = 32'h1357_9BDF;

    logic        clk, rst_n, jump_en, hold;
    logic [31:0] jump_addr;
    logic        rom_req, inst_valid;
    logic [31:0] rom_addr, rom_data, inst, inst_addr;
    logic        w_rom_req, w_inst_valid;
    logic [31:0] w_rom_addr, w_rom_data, w_inst, w_inst_addr;

    int n_cmp;
    int n_bad;

    instruction_fetch u_dut (
        .clk(clk), .rst_n(rst_n), .jump_en(jump_en), .jump_addr(jump_addr), .hold(hold),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data),
        .inst(inst), .inst_addr(inst_addr), .inst_valid(inst_valid)
    );

    instruction_fetch #(.RESET_ADDR(32'hFFFF_FFF8)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .jump_en(1'b0), .jump_addr(32'h0), .hold(1'b0),
        .rom_req(w_rom_req), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .inst(w_inst), .inst_addr(w_inst_addr), .inst_valid(w_inst_valid)
    );

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return a ^ ROM_KEY;
    endfunction

    // ROM: data for the address strobed at an edge is visible for the following cycle.
    always @(posedge clk) begin
        rom_data   <= rom_req   ? rom_f(rom_addr)   : 32'hDEAD_BEEF;
        w_rom_data <= w_rom_req ? rom_f(w_rom_addr) : 32'hDEAD_BEEF;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset; the next rising edge after return is cycle 0.
    task automatic start();
        @(posedge clk);
        #1;
        rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        #1;
        n_cmp++;
        if ({rom_req, inst_valid, inst, inst_addr} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs: got req=%b v=%b inst=%h addr=%h want req=0 v=0 inst=%h addr=0",
                     rom_req, inst_valid, inst, inst_addr, NOP);
        end
        n_cmp++;
        if ({w_rom_req, w_inst_valid, w_inst, w_inst_addr} !== {1'b0, 1'b0, NOP, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_outputs_wrap: got req=%b v=%b inst=%h addr=%h",
                     w_rom_req, w_inst_valid, w_inst, w_inst_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({rom_req, rom_addr} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0", rom_req, rom_addr);
        end
        tick();
        n_cmp++;
        if ({inst_valid, rom_req, rom_addr} !== {1'b0, 1'b1, 32'h4}) begin
            n_bad++;
            $display("FAIL cycle1_state: got v=%b req=%b raddr=%h want v=0 req=1 raddr=4",
                     inst_valid, rom_req, rom_addr);
        end
    endtask

    task automatic test_stream();
        start();
        for (int e = 0; e <= 5; e++) begin
            tick();
            if (e >= 1) begin
                n_cmp++;
                if ({inst_valid, inst_addr, inst, rom_req} !==
                    {1'b1, 32'(4 * (e - 1)), rom_f(32'(4 * (e - 1))), 1'b1}) begin
                    n_bad++;
                    $display("FAIL stream_e%0d: got v=%b addr=%h inst=%h req=%b want addr=%h",
                             e, inst_valid, inst_addr, inst, rom_req, 32'(4 * (e - 1)));
                end
            end
        end
    endtask

    task automatic test_hold();
        start();
        for (int e = 0; e <= 3; e++) tick();
        hold = 1'b1;
        #1;
        n_cmp++;
        if (rom_req !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_req_drop: got req=%b want 0", rom_req);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if ({inst_valid, inst_addr, rom_req} !== {1'b1, 32'h8, 1'b0}) begin
                n_bad++;
                $display("FAIL hold_k%0d: got v=%b addr=%h req=%b want v=1 addr=8 req=0",
                         k, inst_valid, inst_addr, rom_req);
            end
        end
        hold = 1'b0;
        #1;
        n_cmp++;
        if ({rom_req, rom_addr} !== {1'b1, 32'h10}) begin
            n_bad++;
            $display("FAIL hold_release_req: got req=%b addr=%h want req=1 addr=10", rom_req, rom_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({inst_valid, inst_addr, inst} !== {1'b1, 32'(12 + 4 * k), rom_f(32'(12 + 4 * k))}) begin
                n_bad++;
                $display("FAIL hold_resume_k%0d: got v=%b addr=%h inst=%h want addr=%h",
                         k, inst_valid, inst_addr, inst, 32'(12 + 4 * k));
            end
        end
    endtask

    task automatic test_jump();
        start();
        for (int e = 0; e <= 5; e++) tick();
        jump_en = 1'b1; jump_addr = 32'h0000_0103;
        #1;
        n_cmp++;
        if (rom_req !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_no_req: got req=%b want 0", rom_req);
        end
        tick();
        jump_en = 1'b0;
        #1;
        n_cmp++;
        if ({inst_valid, rom_req, rom_addr} !== {1'b0, 1'b1, 32'h100}) begin
            n_bad++;
            $display("FAIL jump_t1: got v=%b req=%b raddr=%h want v=0 req=1 raddr=100",
                     inst_valid, rom_req, rom_addr);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL jump_t2: got v=%b addr=%h want v=0", inst_valid, inst_addr);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_addr, inst} !== {1'b1, 32'h100, rom_f(32'h100)}) begin
            n_bad++;
            $display("FAIL jump_t3: got v=%b addr=%h inst=%h want v=1 addr=100", inst_valid, inst_addr, inst);
        end
        tick();
        n_cmp++;
        if ({inst_valid, inst_addr} !== {1'b1, 32'h104}) begin
            n_bad++;
            $display("FAIL jump_t4: got v=%b addr=%h want v=1 addr=104", inst_valid, inst_addr);
        end
    endtask

    task automatic test_back_to_back_jump();
        start();
        for (int e = 0; e <= 3; e++) tick();
        jump_en = 1'b1; jump_addr = 32'h40;
        tick();
        jump_addr = 32'h80;
        #1;
        n_cmp++;
        if ({inst_valid, rom_req} !== {1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_second: got v=%b req=%b want v=0 req=0", inst_valid, rom_req);
        end
        tick();
        jump_en = 1'b0;
        #1;
        n_cmp++;
        if ({inst_valid, rom_req, rom_addr} !== {1'b0, 1'b1, 32'h80}) begin
            n_bad++;
            $display("FAIL b2b_req: got v=%b req=%b raddr=%h want v=0 req=1 raddr=80",
                     inst_valid, rom_req, rom_addr);
        end
        tick();
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_gap: got v=%b addr=%h want v=0", inst_valid, inst_addr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if ({inst_valid, inst_addr} !== {1'b1, 32'(32'h80 + 4 * k)}) begin
                n_bad++;
                $display("FAIL b2b_out_k%0d: got v=%b addr=%h want addr=%h",
                         k, inst_valid, inst_addr, 32'(32'h80 + 4 * k));
            end
        end
    endtask

    task automatic test_jump_hold();
        start();
        for (int e = 0; e <= 2; e++) tick();
        hold = 1'b1;
        tick();
        n_cmp++;
        if ({inst_valid, inst_addr} !== {1'b1, 32'h4}) begin
            n_bad++;
            $display("FAIL jh_pre: got v=%b addr=%h want v=1 addr=4", inst_valid, inst_addr);
        end
        jump_en = 1'b1; jump_addr = 32'h200;
        tick();
        jump_en = 1'b0;
        #1;
        n_cmp++;
        if ({inst_valid, inst, rom_req, rom_addr} !== {1'b0, NOP, 1'b1, 32'h200}) begin
            n_bad++;
            $display("FAIL jh_flush: got v=%b inst=%h req=%b raddr=%h want v=0 nop req=1 raddr=200",
                     inst_valid, inst, rom_req, rom_addr);
        end
        tick();
        tick();
        n_cmp++;
        if ({inst_valid, inst_addr} !== {1'b1, 32'h200}) begin
            n_bad++;
            $display("FAIL jh_target: got v=%b addr=%h want v=1 addr=200", inst_valid, inst_addr);
        end
        tick();
        hold = 1'b0;
        tick();
        n_cmp++;
        if ({inst_valid, inst_addr} !== {1'b1, 32'h204}) begin
            n_bad++;
            $display("FAIL jh_resume: got v=%b addr=%h want v=1 addr=204", inst_valid, inst_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hFFFF_FFF8;
        exp_w[1] = 32'hFFFF_FFFC;
        exp_w[2] = 32'h0000_0000;
        exp_w[3] = 32'h0000_0004;
        start();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({w_inst_valid, w_inst_addr, w_inst} !== {1'b1, exp_w[k], rom_f(exp_w[k])}) begin
                n_bad++;
                $display("FAIL wrap_k%0d: got v=%b addr=%h inst=%h want addr=%h",
                         k, w_inst_valid, w_inst_addr, w_inst, exp_w[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        start();
        for (int e = 0; e <= 3; e++) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({inst_valid, inst, inst_addr, rom_req} !== {1'b0, NOP, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got v=%b inst=%h addr=%h req=%b want v=0 nop addr=0 req=0",
                     inst_valid, inst, inst_addr, rom_req);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if ({inst_valid, inst_addr, inst} !== {1'b1, 32'(4 * k), rom_f(32'(4 * k))}) begin
                n_bad++;
                $display("FAIL restart_k%0d: got v=%b addr=%h inst=%h want addr=%h",
                         k, inst_valid, inst_addr, inst, 32'(4 * k));
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0; hold = 1'b0; jump_en = 1'b0; jump_addr = 32'h0;
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_back_to_back_jump();
        test_jump_hold();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
